// File: rtl/frame_parser.sv
// Strips a 3-beat header, filters on destination, link type and sync word, and forwards the payload.
// Optional statistics counters are enabled by defining FRAME_PARSER_STATS_EN.
module frame_parser #(
    parameter int INPUT_WIDTH      = 64,
    parameter int OUTPUT_WIDTH     = 64,
    parameter bit ACCEPT_BROADCAST = 1'b1
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [INPUT_WIDTH-1:0]    S_AXIS_tdata,
    input  logic [INPUT_WIDTH/8-1:0]  S_AXIS_tkeep,
    input  logic                      S_AXIS_tvalid,
    input  logic                      S_AXIS_tlast,
    output logic                      S_AXIS_tready,
    output logic [OUTPUT_WIDTH-1:0]   M_AXIS_tdata,
    output logic [OUTPUT_WIDTH/8-1:0] M_AXIS_tkeep,
    output logic                      M_AXIS_tvalid,
    output logic                      M_AXIS_tlast,
    input  logic                      M_AXIS_tready,
    input  logic [47:0]               Local_Address,
    input  logic [15:0]               Link_Type,
    input  logic [15:0]               SyncWord,
    output logic [47:0]               Rx_Source_Address,
    output logic [13:0]               Rx_Packet_Size,
    output logic                      Err_Runt,
    output logic                      Err_Length,
    output logic                      Frame_Dropped,
    output logic [15:0]               Frames_Ok,
    output logic [15:0]               Frames_Dropped,
    output logic [2:0]                FPState
);

    typedef enum logic [2:0] {
        HDR0    = 3'd0,
        HDR1    = 3'd1,
        HDR2    = 3'd2,
        PAYLOAD = 3'd3,
        DROP    = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        accept;
    logic        out_free;
    logic        dest_match, dest_match_q, type_match_q, sync_match_q;
    logic [15:0] src_hi_q;
    logic [31:0] src_lo_q;
    logic [13:0] count_q, count_inc;
    logic        count_hit;
    logic        runt_d, len_d, drop_d;

    // Both streams: a beat transfers on a rising edge where tvalid and tready are high;
    // a source holds tvalid and its data stable until that happens.
    assign out_free      = !M_AXIS_tvalid || M_AXIS_tready;
    assign S_AXIS_tready = (state_q == PAYLOAD) ? out_free : 1'b1;
    assign accept        = S_AXIS_tvalid && S_AXIS_tready;
    assign count_inc     = count_q + 14'd1;
    assign count_hit     = (count_inc == Rx_Packet_Size);
    assign dest_match    = (S_AXIS_tdata[63:16] == Local_Address) ||
                           (ACCEPT_BROADCAST && (S_AXIS_tdata[63:16] == 48'hFFFF_FFFF_FFFF));
    assign FPState       = state_q;

    always_comb begin
        state_d = state_q;
        runt_d  = 1'b0;
        len_d   = 1'b0;
        drop_d  = 1'b0;
        if (accept) begin
            case (state_q)
                HDR0, HDR1: begin
                    if (S_AXIS_tlast) begin
                        state_d = HDR0;
                        runt_d  = 1'b1;
                        drop_d  = 1'b1;
                    end else if (state_q == HDR0) begin
                        state_d = HDR1;
                    end else begin
                        state_d = HDR2;
                    end
                end
                HDR2: begin
                    if (S_AXIS_tlast) begin
                        state_d = HDR0;
                        runt_d  = 1'b1;
                        drop_d  = 1'b1;
                    end else if (S_AXIS_tdata[13:0] == 14'd0) begin
                        state_d = DROP;
                        len_d   = 1'b1;
                        drop_d  = 1'b1;
                    end else if (dest_match_q && type_match_q && sync_match_q) begin
                        state_d = PAYLOAD;
                    end else begin
                        state_d = DROP;
                        drop_d  = 1'b1;
                    end
                end
                PAYLOAD: begin
                    // Early tlast ends the frame short; reaching the count without tlast discards the rest.
                    if (S_AXIS_tlast) begin
                        state_d = HDR0;
                        len_d   = !count_hit;
                    end else if (count_hit) begin
                        state_d = DROP;
                        len_d   = 1'b1;
                    end
                end
                DROP: begin
                    if (S_AXIS_tlast) state_d = HDR0;
                end
                default: state_d = HDR0;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) state_q <= HDR0;
        else        state_q <= state_d;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            M_AXIS_tdata      <= '0;
            M_AXIS_tkeep      <= '0;
            M_AXIS_tvalid     <= 1'b0;
            M_AXIS_tlast      <= 1'b0;
            Rx_Source_Address <= '0;
            Rx_Packet_Size    <= '0;
            Err_Runt          <= 1'b0;
            Err_Length        <= 1'b0;
            Frame_Dropped     <= 1'b0;
            dest_match_q      <= 1'b0;
            type_match_q      <= 1'b0;
            sync_match_q      <= 1'b0;
            src_hi_q          <= '0;
            src_lo_q          <= '0;
            count_q           <= '0;
        end else begin
            Err_Runt      <= runt_d;
            Err_Length    <= len_d;
            Frame_Dropped <= drop_d;
            if (M_AXIS_tvalid && M_AXIS_tready) M_AXIS_tvalid <= 1'b0;
            if (accept) begin
                case (state_q)
                    HDR0: begin
                        dest_match_q <= dest_match;
                        src_hi_q     <= S_AXIS_tdata[15:0];
                    end
                    HDR1: begin
                        src_lo_q     <= S_AXIS_tdata[63:32];
                        type_match_q <= (S_AXIS_tdata[31:16] == Link_Type);
                        sync_match_q <= (S_AXIS_tdata[15:0] == SyncWord);
                    end
                    HDR2: begin
                        if (state_d == PAYLOAD) begin
                            Rx_Source_Address <= {src_hi_q, src_lo_q};
                            Rx_Packet_Size    <= S_AXIS_tdata[13:0];
                            count_q           <= '0;
                        end
                    end
                    PAYLOAD: begin
                        M_AXIS_tdata  <= S_AXIS_tdata;
                        M_AXIS_tkeep  <= S_AXIS_tkeep;
                        M_AXIS_tvalid <= 1'b1;
                        M_AXIS_tlast  <= S_AXIS_tlast || count_hit;
                        count_q       <= count_inc;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef FRAME_PARSER_STATS_EN
    logic frame_ok;
    assign frame_ok = accept && (state_q == PAYLOAD) && S_AXIS_tlast && count_hit;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            Frames_Ok      <= '0;
            Frames_Dropped <= '0;
        end else begin
            if (frame_ok && (Frames_Ok != 16'hFFFF)) Frames_Ok <= Frames_Ok + 16'd1;
            if (Frame_Dropped && (Frames_Dropped != 16'hFFFF)) Frames_Dropped <= Frames_Dropped + 16'd1;
        end
    end
`else
    assign Frames_Ok      = '0;
    assign Frames_Dropped = '0;
`endif

endmodule

// File: tb/tb_frame_parser.sv
// Directed bench for frame_parser: header filtering, length errors, runts, backpressure and reset.
`timescale 1ns/1ps
module tb_frame_parser;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [63:0] S_AXIS_tdata = '0;
    logic [7:0]  S_AXIS_tkeep = '0;
    logic        S_AXIS_tvalid = 1'b0;
    logic        S_AXIS_tlast = 1'b0;
    logic        S_AXIS_tready;
    logic [63:0] M_AXIS_tdata;
    logic [7:0]  M_AXIS_tkeep;
    logic        M_AXIS_tvalid;
    logic        M_AXIS_tlast;
    logic        M_AXIS_tready = 1'b1;
    logic [47:0] Local_Address = 48'h0A0B_0C0D_0E0F;
    logic [15:0] Link_Type = 16'h88B5;
    logic [15:0] SyncWord = 16'hA5A5;
    logic [47:0] Rx_Source_Address;
    logic [13:0] Rx_Packet_Size;
    logic        Err_Runt, Err_Length, Frame_Dropped;
    logic [15:0] Frames_Ok, Frames_Dropped;
    logic [2:0]  FPState;

    localparam logic [47:0] LOCAL = 48'h0A0B_0C0D_0E0F;
    localparam logic [47:0] SRC   = 48'h0123_4567_89AB;
`ifdef FRAME_PARSER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    frame_parser dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXIS_tdata(S_AXIS_tdata), .S_AXIS_tkeep(S_AXIS_tkeep), .S_AXIS_tvalid(S_AXIS_tvalid),
        .S_AXIS_tlast(S_AXIS_tlast), .S_AXIS_tready(S_AXIS_tready),
        .M_AXIS_tdata(M_AXIS_tdata), .M_AXIS_tkeep(M_AXIS_tkeep), .M_AXIS_tvalid(M_AXIS_tvalid),
        .M_AXIS_tlast(M_AXIS_tlast), .M_AXIS_tready(M_AXIS_tready),
        .Local_Address(Local_Address), .Link_Type(Link_Type), .SyncWord(SyncWord),
        .Rx_Source_Address(Rx_Source_Address), .Rx_Packet_Size(Rx_Packet_Size),
        .Err_Runt(Err_Runt), .Err_Length(Err_Length), .Frame_Dropped(Frame_Dropped),
        .Frames_Ok(Frames_Ok), .Frames_Dropped(Frames_Dropped), .FPState(FPState)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int failures = 0;
    int exp_ok = 0;
    int exp_dropped = 0;
    logic [72:0] exp_q[$];
    logic [72:0] got_q[$];
    int runt_cnt, len_cnt, drop_cnt, hold_err, stall_err;
    logic held = 1'b0;
    logic [72:0] held_beat = '0;
    logic toggle_en = 1'b0;

    // Output monitor: records transfers and pulses, and watches held-beat stability.
    always @(negedge ACLK) begin
        if (held && !ARESET && (!M_AXIS_tvalid || ({M_AXIS_tlast, M_AXIS_tkeep, M_AXIS_tdata} !== held_beat)))
            hold_err++;
        if (FPState == 3'd3 && M_AXIS_tvalid && !M_AXIS_tready && S_AXIS_tready) stall_err++;
        if (M_AXIS_tvalid && M_AXIS_tready) got_q.push_back({M_AXIS_tlast, M_AXIS_tkeep, M_AXIS_tdata});
        if (Err_Runt) runt_cnt++;
        if (Err_Length) len_cnt++;
        if (Frame_Dropped) drop_cnt++;
        held = M_AXIS_tvalid && !M_AXIS_tready && !ARESET;
        held_beat = {M_AXIS_tlast, M_AXIS_tkeep, M_AXIS_tdata};
    end

    always @(posedge ACLK) begin
        if (toggle_en) begin
            #1;
            M_AXIS_tready = ~M_AXIS_tready;
        end
    end

    function automatic logic [63:0] pay(input logic [7:0] tag, input int i);
        return {8'hD0, tag, 32'h0, i[15:0]};
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    task automatic clear_sb();
        exp_q.delete();
        got_q.delete();
        runt_cnt = 0; len_cnt = 0; drop_cnt = 0; hold_err = 0; stall_err = 0;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        logic rdy;
        int n;
        n = 0;
        S_AXIS_tdata = d; S_AXIS_tkeep = k; S_AXIS_tlast = l; S_AXIS_tvalid = 1'b1;
        forever begin
            @(negedge ACLK);
            rdy = S_AXIS_tready;
            @(posedge ACLK);
            #1;
            if (rdy) break;
            n++;
            if (n > 200) begin
                checks++; failures++;
                $display("FAIL send_timeout: got no S_AXIS_tready in 200 cycles, required a transfer");
                break;
            end
        end
        S_AXIS_tvalid = 1'b0; S_AXIS_tlast = 1'b0;
    endtask

    task automatic send_header(input logic [47:0] dest, input logic [15:0] sync, input logic [13:0] size);
        send_beat({dest, SRC[47:32]}, 8'hFF, 1'b0);
        send_beat({SRC[31:0], 16'h88B5, sync}, 8'hFF, 1'b0);
        send_beat({2'b10, 48'hDEAD_BEEF_CAFE, size}, 8'hFF, 1'b0);
    endtask

    task automatic send_frame(input logic [47:0] dest, input logic [15:0] sync, input logic [13:0] size,
                              input int npay, input logic [7:0] tag);
        send_header(dest, sync, size);
        for (int i = 0; i < npay; i++)
            send_beat(pay(tag, i), (i == npay - 1) ? 8'h0F : 8'hFF, i == npay - 1);
    endtask

    task automatic test_reset();
        checks++; if (FPState !== 3'd0) begin failures++; $display("FAIL rst_state: got %0d expected 0", FPState); end
        checks++; if (M_AXIS_tvalid !== 1'b0) begin failures++; $display("FAIL rst_tvalid: got %b expected 0", M_AXIS_tvalid); end
        checks++; if (M_AXIS_tlast !== 1'b0) begin failures++; $display("FAIL rst_tlast: got %b expected 0", M_AXIS_tlast); end
        checks++; if ({M_AXIS_tdata, M_AXIS_tkeep} !== 72'h0) begin failures++; $display("FAIL rst_data: got %h expected 0", {M_AXIS_tdata, M_AXIS_tkeep}); end
        checks++; if ({Err_Runt, Err_Length, Frame_Dropped} !== 3'b000) begin failures++; $display("FAIL rst_pulses: got %b expected 000", {Err_Runt, Err_Length, Frame_Dropped}); end
        checks++; if ({Rx_Source_Address, Rx_Packet_Size} !== 62'h0) begin failures++; $display("FAIL rst_rx: got %h expected 0", {Rx_Source_Address, Rx_Packet_Size}); end
        checks++; if ({Frames_Ok, Frames_Dropped} !== 32'h0) begin failures++; $display("FAIL rst_counters: got %h expected 0", {Frames_Ok, Frames_Dropped}); end
        checks++; if (S_AXIS_tready !== 1'b1) begin failures++; $display("FAIL rst_tready: got %b expected 1", S_AXIS_tready); end
        ARESET = 1'b0;
        wait_cycles(1);
    endtask

    task automatic test_good_frame();
        clear_sb();
        for (int i = 0; i < 4; i++) exp_q.push_back({i == 3, (i == 3) ? 8'h0F : 8'hFF, pay(8'h01, i)});
        send_frame(LOCAL, 16'hA5A5, 14'd4, 4, 8'h01);
        exp_ok++;
        wait_cycles(5);
        checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL good_count: got %0d beats expected %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL good_beat%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (Rx_Source_Address !== SRC) begin failures++; $display("FAIL good_src: got %h expected %h", Rx_Source_Address, SRC); end
        checks++; if (Rx_Packet_Size !== 14'd4) begin failures++; $display("FAIL good_size: got %0d expected 4", Rx_Packet_Size); end
        checks++; if (Frames_Ok !== (STATS ? 16'(exp_ok) : 16'd0)) begin failures++; $display("FAIL good_frames_ok: got %0d expected %0d", Frames_Ok, STATS ? exp_ok : 0); end
        checks++; if (len_cnt + drop_cnt + runt_cnt != 0) begin failures++; $display("FAIL good_pulses: got %0d pulses expected 0", len_cnt + drop_cnt + runt_cnt); end
        checks++; if (FPState !== 3'd0) begin failures++; $display("FAIL good_state: got %0d expected 0", FPState); end
    endtask

    task automatic test_sync_mismatch();
        clear_sb();
        send_frame(LOCAL, 16'h0000, 14'd7, 4, 8'h02);
        exp_dropped++;
        wait_cycles(5);
        checks++; if (got_q.size() != 0) begin failures++; $display("FAIL sync_count: got %0d beats expected 0", got_q.size()); end
        checks++; if (drop_cnt != 1) begin failures++; $display("FAIL sync_dropped_pulse: got %0d expected 1", drop_cnt); end
        checks++; if (Frames_Dropped !== (STATS ? 16'(exp_dropped) : 16'd0)) begin failures++; $display("FAIL sync_frames_dropped: got %0d expected %0d", Frames_Dropped, STATS ? exp_dropped : 0); end
        checks++; if (Rx_Packet_Size !== 14'd4) begin failures++; $display("FAIL sync_rx_kept: got %0d expected 4", Rx_Packet_Size); end
        checks++; if (FPState !== 3'd0) begin failures++; $display("FAIL sync_state: got %0d expected 0", FPState); end
    endtask

    task automatic test_broadcast();
        clear_sb();
        exp_q.push_back({1'b1, 8'h0F, pay(8'h03, 0)});
        send_frame(48'hFFFF_FFFF_FFFF, 16'hA5A5, 14'd1, 1, 8'h03);
        exp_ok++;
        wait_cycles(5);
        checks++; if (got_q.size() != 1) begin failures++; $display("FAIL bcast_count: got %0d beats expected 1", got_q.size()); end
        if (got_q.size() > 0) begin
            checks++; if (got_q[0] !== exp_q[0]) begin failures++; $display("FAIL bcast_beat: got %h expected %h", got_q[0], exp_q[0]); end
        end
        checks++; if (Rx_Packet_Size !== 14'd1) begin failures++; $display("FAIL bcast_size: got %0d expected 1", Rx_Packet_Size); end
        checks++; if (Frames_Ok !== (STATS ? 16'(exp_ok) : 16'd0)) begin failures++; $display("FAIL bcast_frames_ok: got %0d expected %0d", Frames_Ok, STATS ? exp_ok : 0); end
    endtask

    task automatic test_overlength();
        clear_sb();
        exp_q.push_back({1'b0, 8'hFF, pay(8'h05, 0)});
        exp_q.push_back({1'b1, 8'hFF, pay(8'h05, 1)});
        send_frame(LOCAL, 16'hA5A5, 14'd2, 5, 8'h05);
        wait_cycles(5);
        checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL over_count: got %0d beats expected %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL over_beat%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (len_cnt != 1) begin failures++; $display("FAIL over_err_length: got %0d expected 1", len_cnt); end
        checks++; if (drop_cnt != 0) begin failures++; $display("FAIL over_dropped: got %0d expected 0", drop_cnt); end
        checks++; if (Frames_Ok !== (STATS ? 16'(exp_ok) : 16'd0)) begin failures++; $display("FAIL over_frames_ok: got %0d expected %0d", Frames_Ok, STATS ? exp_ok : 0); end
        checks++; if (FPState !== 3'd0) begin failures++; $display("FAIL over_state: got %0d expected 0", FPState); end
    endtask

    task automatic test_short();
        clear_sb();
        exp_q.push_back({1'b0, 8'hFF, pay(8'h06, 0)});
        exp_q.push_back({1'b1, 8'h0F, pay(8'h06, 1)});
        send_frame(LOCAL, 16'hA5A5, 14'd4, 2, 8'h06);
        wait_cycles(5);
        checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL short_count: got %0d beats expected %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL short_beat%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (len_cnt != 1) begin failures++; $display("FAIL short_err_length: got %0d expected 1", len_cnt); end
        checks++; if (Frames_Ok !== (STATS ? 16'(exp_ok) : 16'd0)) begin failures++; $display("FAIL short_frames_ok: got %0d expected %0d", Frames_Ok, STATS ? exp_ok : 0); end
    endtask

    task automatic test_runt_back_to_back();
        clear_sb();
        send_beat({LOCAL, SRC[47:32]}, 8'hFF, 1'b0);
        send_beat({SRC[31:0], 16'h88B5, 16'hA5A5}, 8'hFF, 1'b1);
        exp_dropped++;
        exp_q.push_back({1'b0, 8'hFF, pay(8'h07, 0)});
        exp_q.push_back({1'b1, 8'h0F, pay(8'h07, 1)});
        send_frame(LOCAL, 16'hA5A5, 14'd2, 2, 8'h07);
        exp_ok++;
        wait_cycles(5);
        checks++; if (runt_cnt != 1) begin failures++; $display("FAIL runt_err_runt: got %0d expected 1", runt_cnt); end
        checks++; if (drop_cnt != 1) begin failures++; $display("FAIL runt_dropped: got %0d expected 1", drop_cnt); end
        checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL runt_next_count: got %0d beats expected %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL runt_next_beat%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (Frames_Dropped !== (STATS ? 16'(exp_dropped) : 16'd0)) begin failures++; $display("FAIL runt_frames_dropped: got %0d expected %0d", Frames_Dropped, STATS ? exp_dropped : 0); end
    endtask

    task automatic test_zero_size();
        clear_sb();
        send_frame(LOCAL, 16'hA5A5, 14'd0, 3, 8'h08);
        exp_dropped++;
        wait_cycles(5);
        checks++; if (got_q.size() != 0) begin failures++; $display("FAIL zero_count: got %0d beats expected 0", got_q.size()); end
        checks++; if (len_cnt != 1) begin failures++; $display("FAIL zero_err_length: got %0d expected 1", len_cnt); end
        checks++; if (drop_cnt != 1) begin failures++; $display("FAIL zero_dropped: got %0d expected 1", drop_cnt); end
        checks++; if (Rx_Packet_Size !== 14'd2) begin failures++; $display("FAIL zero_rx_kept: got %0d expected 2", Rx_Packet_Size); end
        checks++; if (FPState !== 3'd0) begin failures++; $display("FAIL zero_state: got %0d expected 0", FPState); end
    endtask

    task automatic test_backpressure();
        clear_sb();
        for (int i = 0; i < 4; i++) exp_q.push_back({i == 3, (i == 3) ? 8'h0F : 8'hFF, pay(8'h09, i)});
        M_AXIS_tready = 1'b1;
        toggle_en = 1'b1;
        send_frame(LOCAL, 16'hA5A5, 14'd4, 4, 8'h09);
        exp_ok++;
        wait_cycles(10);
        toggle_en = 1'b0;
        wait_cycles(1);
        M_AXIS_tready = 1'b1;
        wait_cycles(3);
        checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL bp_count: got %0d beats expected %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL bp_beat%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (hold_err != 0) begin failures++; $display("FAIL bp_hold_stable: got %0d unstable cycles expected 0", hold_err); end
        checks++; if (stall_err != 0) begin failures++; $display("FAIL bp_s_tready: got %0d cycles ready while held expected 0", stall_err); end
        checks++; if (Frames_Ok !== (STATS ? 16'(exp_ok) : 16'd0)) begin failures++; $display("FAIL bp_frames_ok: got %0d expected %0d", Frames_Ok, STATS ? exp_ok : 0); end
    endtask

    task automatic test_mid_reset();
        clear_sb();
        M_AXIS_tready = 1'b0;
        send_header(LOCAL, 16'hA5A5, 14'd4);
        send_beat(pay(8'h0A, 0), 8'hFF, 1'b0);
        wait_cycles(2);
        checks++; if (FPState !== 3'd3 || M_AXIS_tvalid !== 1'b1) begin failures++; $display("FAIL mrst_pre: got state %0d tvalid %b expected 3 1", FPState, M_AXIS_tvalid); end
        ARESET = 1'b1;
        wait_cycles(1);
        checks++; if (FPState !== 3'd0) begin failures++; $display("FAIL mrst_state: got %0d expected 0", FPState); end
        checks++; if ({M_AXIS_tvalid, M_AXIS_tlast} !== 2'b00) begin failures++; $display("FAIL mrst_valid_last: got %b expected 00", {M_AXIS_tvalid, M_AXIS_tlast}); end
        checks++; if ({M_AXIS_tdata, M_AXIS_tkeep} !== 72'h0) begin failures++; $display("FAIL mrst_data: got %h expected 0", {M_AXIS_tdata, M_AXIS_tkeep}); end
        checks++; if ({Rx_Source_Address, Rx_Packet_Size} !== 62'h0) begin failures++; $display("FAIL mrst_rx: got %h expected 0", {Rx_Source_Address, Rx_Packet_Size}); end
        checks++; if ({Frames_Ok, Frames_Dropped} !== 32'h0) begin failures++; $display("FAIL mrst_counters: got %h expected 0", {Frames_Ok, Frames_Dropped}); end
        ARESET = 1'b0;
        M_AXIS_tready = 1'b1;
        exp_ok = 0;
        exp_dropped = 0;
        wait_cycles(1);
        clear_sb();
        for (int i = 0; i < 3; i++) exp_q.push_back({i == 2, (i == 2) ? 8'h0F : 8'hFF, pay(8'h0B, i)});
        send_frame(LOCAL, 16'hA5A5, 14'd3, 3, 8'h0B);
        exp_ok++;
        wait_cycles(5);
        checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL mrst_next_count: got %0d beats expected %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL mrst_next_beat%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (Rx_Source_Address !== SRC) begin failures++; $display("FAIL mrst_next_src: got %h expected %h", Rx_Source_Address, SRC); end
        checks++; if (Frames_Ok !== (STATS ? 16'(exp_ok) : 16'd0)) begin failures++; $display("FAIL mrst_frames_ok: got %0d expected %0d", Frames_Ok, STATS ? exp_ok : 0); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200us, required the test sequence to finish");
        $fatal(1);
    end

    initial begin
        wait_cycles(3);
        test_reset();
        test_good_frame();
        test_sync_mismatch();
        test_broadcast();
        test_overlength();
        test_short();
        test_runt_back_to_back();
        test_zero_size();
        test_backpressure();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frame_parser.md
FRAME_PARSER -- requirements
Module: frame_parser

Interface
REQ-001 Parameter INPUT_WIDTH, default 64, S_AXIS tdata width; only 64 is supported.
REQ-002 Parameter OUTPUT_WIDTH, default 64, M_AXIS tdata width; SHALL equal INPUT_WIDTH.
REQ-003 Parameter ACCEPT_BROADCAST, default 1, if 1 a destination of 48'hFFFF_FFFF_FFFF also passes the filter.
REQ-004 Clocking SHALL be: one clock; reset is synchronous and active-high.
REQ-005 ACLK  in  1  sole clock; all logic on the rising edge.
REQ-006 ARESET  in  1  synchronous active-high reset.
REQ-007 S_AXIS_tdata/tkeep/tvalid/tlast  in  64/8/1/1  framed input stream; S_AXIS_tready  out  1.
REQ-008 M_AXIS_tdata/tkeep/tvalid/tlast  out  64/8/1/1  payload output stream; M_AXIS_tready  in  1.
REQ-009 Local_Address  in  48, Link_Type  in  16, SyncWord  in  16  filter values, sampled on header beats.
REQ-010 Rx_Source_Address  out  48, Rx_Packet_Size  out  14  fields latched from the last accepted header.
REQ-011 Err_Runt, Err_Length, Frame_Dropped  out  1 each  single-cycle status pulses.
REQ-012 Frames_Ok, Frames_Dropped  out  16 each  statistics counters.
REQ-013 FPState  out  3  current state encoding, for debug.

Function
REQ-014 Header layout SHALL be: beat0 [63:16]=Dest, [15:0]=Src[47:32]; beat1 [63:32]=Src[31:0], [31:16]=Link_Type, [15:0]=SyncWord; beat2 [13:0]=Packet_Size (payload beat count), [63:14] ignored.
REQ-015 States SHALL be HDR0=0, HDR1=1, HDR2=2, PAYLOAD=3, DROP=4; a beat is consumed only when S_AXIS_tvalid and S_AXIS_tready are both high.
REQ-016 S_AXIS_tready SHALL be 1 in HDR0, HDR1, HDR2 and DROP; in PAYLOAD it SHALL be (!M_AXIS_tvalid || M_AXIS_tready).
REQ-017 HDR0->HDR1 on a beat, latching the Dest match and Src[47:32]; HDR1->HDR2 on a beat, latching Src[31:0] and the Link_Type and SyncWord matches.
REQ-018 On the HDR2 beat: if all matches hold, go to PAYLOAD, update Rx_Source_Address and Rx_Packet_Size, and clear the payload counter; otherwise go to DROP.
REQ-019 Packet_Size==0 in HDR2 with no tlast SHALL go to DROP and pulse Err_Length.
REQ-020 tlast on any header beat SHALL return to HDR0 next cycle and pulse both Err_Runt and Frame_Dropped.
REQ-021 In PAYLOAD each accepted beat SHALL be registered to M_AXIS with tdata and tkeep unchanged, appearing one cycle after acceptance; M_AXIS_tvalid SHALL be held until accepted, with data stable.
REQ-022 M_AXIS_tlast SHALL be set on an input tlast beat or on the beat where the payload count reaches Packet_Size, whichever comes first.
REQ-023 Count reached without input tlast: go to DROP to discard the remainder and pulse Err_Length.
REQ-024 Input tlast before the count is reached: forward it with tlast, pulse Err_Length, go to HDR0.
REQ-025 DROP SHALL discard beats until a tlast beat, then return to HDR0; entry from the header path pulses Frame_Dropped once.
REQ-026 Frames_Ok SHALL increment when a payload tlast beat is accepted without Err_Length; Frames_Dropped SHALL increment on each Frame_Dropped pulse; both SHALL saturate at 16'hFFFF.

Reset
REQ-027 ARESET SHALL force HDR0, M_AXIS_tvalid=0, tlast=0, tdata/tkeep=0, pulses=0, Rx_* =0 and counters=0, taking effect on the next edge.
REQ-028 Reset mid-frame SHALL abandon the frame; the next beats after reset SHALL be parsed as a new header.

Configuration
REQ-029 Macro FRAME_PARSER_STATS_EN: when defined, Frames_Ok and Frames_Dropped SHALL count per REQ-026; when undefined, both SHALL be constant 0 and the counter logic SHALL be absent.

Verification
REQ-030 Matching header (Dest=Local_Address, Link_Type=16'h88B5, SyncWord=16'hA5A5, Size=4) plus 4 payload beats ending in tlast -> 4 M beats, tlast on the 4th, Frames_Ok=1.
REQ-031 Same frame with SyncWord=16'h0000 -> no M beats, one Frame_Dropped pulse, Frames_Dropped=1, then HDR0.
REQ-032 Size=2 with 5 payload beats -> 2 M beats, tlast on the 2nd, Err_Length pulse, 3 beats discarded.
REQ-033 tlast on beat1 -> Err_Runt pulse, immediate next frame parsed correctly.
REQ-034 M_AXIS_tready toggling 1010 during a 4-beat payload -> data order preserved, no loss or duplication, S_AXIS_tready low while output held.
REQ-035 ARESET asserted mid-payload -> all outputs reach reset values next edge; subsequent good frame passes.
